// File: rtl/wb_adapter_32_8.sv
// wb_adapter_32_8: bridges a 32-bit Wishbone master onto an 8-bit Wishbone slave.
// Each selected byte lane of an upstream access becomes one downstream byte cycle,
// issued lowest lane first, with one idle cycle between consecutive bytes.
// Byte order is little-endian: lane 0 = bits 7:0 = byte offset 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wbm_adr_i/dat_i/we_i/
//   sel_i/stb_i/cyc_i        upstream request (adr bits 1:0 ignored)
//   wbm_dat_o/ack_o/err_o    upstream response, registered
//   wbs_adr_o/dat_o/we_o/
//   stb_o/cyc_o              downstream byte request, registered
//   wbs_dat_i/ack_i/err_i    downstream response
module wb_adapter_32_8 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wbm_adr_i,
  input  logic [31:0] wbm_dat_i,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_we_i,
  input  logic [3:0]  wbm_sel_i,
  input  logic        wbm_stb_i,
  input  logic        wbm_cyc_i,
  output logic        wbm_ack_o,
  output logic        wbm_err_o,
  output logic [31:0] wbs_adr_o,
  output logic [7:0]  wbs_dat_o,
  input  logic [7:0]  wbs_dat_i,
  output logic        wbs_we_o,
  output logic        wbs_stb_o,
  output logic        wbs_cyc_o,
  input  logic        wbs_ack_i,
  input  logic        wbs_err_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e      r_state, w_state_d;
  logic [29:0] r_adr, w_adr_d;
  logic [31:0] r_dat, w_dat_d;
  logic        r_we, w_we_d;
  logic [3:0]  r_sel, w_sel_d;     // lanes still to be transferred
  logic [1:0]  r_idx, w_idx_d;     // lane of the byte currently on the bus
  logic [31:0] r_buf, w_buf_d;     // read data gathered so far
  logic        r_abort, w_abort_d; // master withdrew while a byte was in flight

  logic [31:0] r_wbm_dat, w_wbm_dat_d;
  logic        r_wbm_ack, w_wbm_ack_d;
  logic        r_wbm_err, w_wbm_err_d;
  logic [31:0] r_wbs_adr, w_wbs_adr_d;
  logic [7:0]  r_wbs_dat, w_wbs_dat_d;
  logic        r_wbs_we, w_wbs_we_d;
  logic        r_wbs_cyc, w_wbs_cyc_d;
  logic        r_wbs_stb, w_wbs_stb_d;

  logic        w_master;
  logic [3:0]  w_sel_rem;
  logic        w_unused;

  assign w_unused = ^wbm_adr_i[1:0];

  function automatic logic [1:0] lowest_idx(input logic [3:0] s);
    if (s[0])      return 2'd0;
    else if (s[1]) return 2'd1;
    else if (s[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always_comb begin
    w_master    = wbm_cyc_i & wbm_stb_i;
    w_sel_rem   = r_sel & ~(4'b0001 << r_idx);
    w_state_d   = r_state;
    w_adr_d     = r_adr;
    w_dat_d     = r_dat;
    w_we_d      = r_we;
    w_sel_d     = r_sel;
    w_idx_d     = r_idx;
    w_buf_d     = r_buf;
    w_abort_d   = r_abort;
    w_wbm_dat_d = r_wbm_dat;
    w_wbm_ack_d = 1'b0;
    w_wbm_err_d = 1'b0;
    w_wbs_adr_d = r_wbs_adr;
    w_wbs_dat_d = r_wbs_dat;
    w_wbs_we_d  = r_wbs_we;
    w_wbs_cyc_d = r_wbs_cyc;
    w_wbs_stb_d = r_wbs_stb;

    case (r_state)
      StIdle: begin
        // Holding off while our own ack/err is visible stops a re-accept of the same request.
        if (w_master && !r_wbm_ack && !r_wbm_err) begin
          w_adr_d   = wbm_adr_i[31:2];
          w_dat_d   = wbm_dat_i;
          w_we_d    = wbm_we_i;
          w_sel_d   = wbm_sel_i;
          w_buf_d   = '0;
          w_abort_d = 1'b0;
          if (wbm_sel_i == 4'h0) begin
            w_wbm_ack_d = 1'b1;
            w_wbm_dat_d = '0;
          end else begin
            w_idx_d     = lowest_idx(wbm_sel_i);
            w_wbs_adr_d = {wbm_adr_i[31:2], w_idx_d};
            w_wbs_dat_d = wbm_dat_i[8*w_idx_d +: 8];
            w_wbs_we_d  = wbm_we_i;
            w_wbs_cyc_d = 1'b1;
            w_wbs_stb_d = 1'b1;
            w_state_d   = StIssue;
          end
        end
      end

      StIssue: begin
        w_abort_d = r_abort | ~w_master;
        if (wbs_err_i) begin
          w_wbs_cyc_d = 1'b0;
          w_wbs_stb_d = 1'b0;
          w_wbm_err_d = ~w_abort_d;
          w_state_d   = StIdle;
        end else if (wbs_ack_i) begin
          w_wbs_cyc_d = 1'b0;
          w_wbs_stb_d = 1'b0;
          w_sel_d     = w_sel_rem;
          if (!r_we) w_buf_d[8*r_idx +: 8] = wbs_dat_i;
          if (w_abort_d) begin
            w_state_d = StIdle;
          end else if (w_sel_rem != 4'h0) begin
            w_state_d = StGap;
          end else begin
            w_wbm_ack_d = 1'b1;
            w_wbm_dat_d = w_buf_d;
            w_state_d   = StIdle;
          end
        end
      end

      StGap: begin
        if (!w_master) begin
          w_state_d = StIdle;
        end else begin
          w_idx_d     = lowest_idx(r_sel);
          w_wbs_adr_d = {r_adr, w_idx_d};
          w_wbs_dat_d = r_dat[8*w_idx_d +: 8];
          w_wbs_we_d  = r_we;
          w_wbs_cyc_d = 1'b1;
          w_wbs_stb_d = 1'b1;
          w_state_d   = StIssue;
        end
      end

      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_adr     <= '0;
      r_dat     <= '0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_idx     <= '0;
      r_buf     <= '0;
      r_abort   <= 1'b0;
      r_wbm_dat <= '0;
      r_wbm_ack <= 1'b0;
      r_wbm_err <= 1'b0;
      r_wbs_adr <= '0;
      r_wbs_dat <= '0;
      r_wbs_we  <= 1'b0;
      r_wbs_cyc <= 1'b0;
      r_wbs_stb <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_adr     <= w_adr_d;
      r_dat     <= w_dat_d;
      r_we      <= w_we_d;
      r_sel     <= w_sel_d;
      r_idx     <= w_idx_d;
      r_buf     <= w_buf_d;
      r_abort   <= w_abort_d;
      r_wbm_dat <= w_wbm_dat_d;
      r_wbm_ack <= w_wbm_ack_d;
      r_wbm_err <= w_wbm_err_d;
      r_wbs_adr <= w_wbs_adr_d;
      r_wbs_dat <= w_wbs_dat_d;
      r_wbs_we  <= w_wbs_we_d;
      r_wbs_cyc <= w_wbs_cyc_d;
      r_wbs_stb <= w_wbs_stb_d;
    end
  end

  assign wbm_dat_o = r_wbm_dat;
  assign wbm_ack_o = r_wbm_ack;
  assign wbm_err_o = r_wbm_err;
  assign wbs_adr_o = r_wbs_adr;
  assign wbs_dat_o = r_wbs_dat;
  assign wbs_we_o  = r_wbs_we;
  assign wbs_cyc_o = r_wbs_cyc;
  assign wbs_stb_o = r_wbs_stb;

endmodule

// File: tb/tb_wb_adapter_32_8.sv
// Directed bench for wb_adapter_32_8: an 8-bit slave model that acks one cycle
// after strobe (or errors at a chosen address), a log of downstream byte cycles,
// and a linear sequence of upstream accesses with hand-computed expectations.
module tb_wb_adapter_32_8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wbm_adr_i = '0;
  logic [31:0] wbm_dat_i = '0;
  logic [31:0] wbm_dat_o;
  logic        wbm_we_i = 1'b0;
  logic [3:0]  wbm_sel_i = '0;
  logic        wbm_stb_i = 1'b0;
  logic        wbm_cyc_i = 1'b0;
  logic        wbm_ack_o;
  logic        wbm_err_o;
  logic [31:0] wbs_adr_o;
  logic [7:0]  wbs_dat_o;
  logic [7:0]  wbs_dat_i = '0;
  logic        wbs_we_o;
  logic        wbs_stb_o;
  logic        wbs_cyc_o;
  logic        wbs_ack_i = 1'b0;
  logic        wbs_err_i = 1'b0;

  wb_adapter_32_8 dut (
    .clk       (clk),
    .rst       (rst),
    .wbm_adr_i (wbm_adr_i),
    .wbm_dat_i (wbm_dat_i),
    .wbm_dat_o (wbm_dat_o),
    .wbm_we_i  (wbm_we_i),
    .wbm_sel_i (wbm_sel_i),
    .wbm_stb_i (wbm_stb_i),
    .wbm_cyc_i (wbm_cyc_i),
    .wbm_ack_o (wbm_ack_o),
    .wbm_err_o (wbm_err_o),
    .wbs_adr_o (wbs_adr_o),
    .wbs_dat_o (wbs_dat_o),
    .wbs_dat_i (wbs_dat_i),
    .wbs_we_o  (wbs_we_o),
    .wbs_stb_o (wbs_stb_o),
    .wbs_cyc_o (wbs_cyc_o),
    .wbs_ack_i (wbs_ack_i),
    .wbs_err_i (wbs_err_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;

  // Slave model
  logic [7:0]  mem [0:4095];
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic        slave_hold = 1'b0;

  always @(posedge clk) begin
    if (!rst && wbs_stb_o && wbs_cyc_o && !wbs_ack_i && !wbs_err_i && !slave_hold) begin
      if (wbs_adr_o == err_addr) begin
        wbs_err_i <= 1'b1;
      end else begin
        wbs_ack_i <= 1'b1;
        if (!wbs_we_o) wbs_dat_i <= mem[wbs_adr_o[11:0]];
      end
    end else begin
      wbs_ack_i <= 1'b0;
      wbs_err_i <= 1'b0;
    end
  end

  // Monitors
  logic [40:0] log_q [$];   // {adr, dat, we} of each completed downstream byte
  int          starts [$];  // cycle stamps of wbs_stb_o rising
  int          ack_cycles = 0;
  int          err_cycles = 0;
  int          ack_at = -1;
  logic        prev_stb = 1'b0;

  always @(posedge clk) begin
    cyc_cnt = cyc_cnt + 1;
    if (!rst && wbs_stb_o && (wbs_ack_i || wbs_err_i))
      log_q.push_back({wbs_adr_o, wbs_dat_o, wbs_we_o});
  end

  always @(negedge clk) begin
    if (wbs_stb_o === 1'b1 && !prev_stb) starts.push_back(cyc_cnt);
    prev_stb = (wbs_stb_o === 1'b1);
    if (wbm_ack_o === 1'b1) begin
      ack_cycles = ack_cycles + 1;
      ack_at = cyc_cnt;
    end
    if (wbm_err_o === 1'b1) err_cycles = err_cycles + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    log_q.delete();
    starts.delete();
    ack_cycles = 0;
    err_cycles = 0;
    ack_at = -1;
  endtask

  // Called at a negedge; returns after the negedge where ack or err is seen.
  task automatic access(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                        input logic [3:0] sel, output logic [31:0] rdata, output int t_req);
    logic done;
    wbm_adr_i = adr;
    wbm_dat_i = dat;
    wbm_we_i  = we;
    wbm_sel_i = sel;
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
    t_req = cyc_cnt;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (wbm_ack_o || wbm_err_o) done = 1'b1;
    end
    rdata = wbm_dat_o;
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    chk("access_done", {63'd0, done}, 64'd1);
  endtask

  logic [31:0] rdata;
  int          t_req;
  logic        seen;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h99;
    mem[12'h204] = 8'h11;
    mem[12'h206] = 8'h33;
    mem[12'h501] = 8'hEE;
    mem[12'h703] = 8'h5A;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", {51'd0, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbm_ack_o, wbm_err_o, wbs_dat_o},
        64'd0);
    chk("reset_data", {wbs_adr_o, wbm_dat_o}, 64'd0);

    // Four-byte write, one gap between bytes, single ack
    clear_logs();
    access(32'h100, 32'hA1B2_C3D4, 1'b1, 4'hF, rdata, t_req);
    @(negedge clk);
    chk("wr4_count", 64'(log_q.size()), 64'd4);
    if (log_q.size() == 4) begin
      chk("wr4_b0", 64'(log_q[0]), 64'({32'h100, 8'hD4, 1'b1}));
      chk("wr4_b1", 64'(log_q[1]), 64'({32'h101, 8'hC3, 1'b1}));
      chk("wr4_b2", 64'(log_q[2]), 64'({32'h102, 8'hB2, 1'b1}));
      chk("wr4_b3", 64'(log_q[3]), 64'({32'h103, 8'hA1, 1'b1}));
    end
    chk("wr4_starts", 64'(starts.size()), 64'd4);
    if (starts.size() == 4) begin
      chk("wr4_first_lat", 64'(starts[0]), 64'(t_req + 1));
      for (int i = 0; i < 3; i++) chk("wr4_gap", 64'(starts[i+1] - starts[i]), 64'd3);
      chk("wr4_ack_lat", 64'(ack_at), 64'(starts[3] + 2));
    end
    chk("wr4_ack_cycles", 64'(ack_cycles), 64'd1);

    // Sparse read: lanes 0 and 2
    clear_logs();
    access(32'h204, 32'hDEAD_BEEF, 1'b0, 4'h5, rdata, t_req);
    @(negedge clk);
    chk("rd5_data", 64'(rdata), 64'h0033_0011);
    chk("rd5_count", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      chk("rd5_b0_adr", 64'(log_q[0][40:9]), 64'h204);
      chk("rd5_b1_adr", 64'(log_q[1][40:9]), 64'h206);
      chk("rd5_we", 64'({log_q[0][0], log_q[1][0]}), 64'd0);
    end
    if (starts.size() == 2) chk("rd5_ack_lat", 64'(ack_at), 64'(starts[1] + 2));
    chk("rd5_ack_cycles", 64'(ack_cycles), 64'd1);

    // Error on the second byte of a write
    clear_logs();
    err_addr = 32'h301;
    access(32'h300, 32'h4433_2211, 1'b1, 4'hF, rdata, t_req);
    chk("err_dat_hold", 64'(rdata), 64'h0033_0011);
    repeat (6) @(negedge clk);
    err_addr = 32'hFFFF_FFFF;
    chk("err_count", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) chk("err_b1_adr", 64'(log_q[1][40:9]), 64'h301);
    chk("err_pulses", 64'(err_cycles), 64'd1);
    chk("err_no_ack", 64'(ack_cycles), 64'd0);

    // sel = 0: immediate ack, no downstream cycle, zero data
    clear_logs();
    access(32'h208, 32'h1234_5678, 1'b0, 4'h0, rdata, t_req);
    @(negedge clk);
    chk("sel0_data", 64'(rdata), 64'd0);
    chk("sel0_no_stb", 64'(starts.size()), 64'd0);
    chk("sel0_ack_lat", 64'(ack_at), 64'(t_req + 1));
    chk("sel0_ack_cycles", 64'(ack_cycles), 64'd1);

    // Master drops cyc during the first byte
    clear_logs();
    wbm_adr_i = 32'h400;
    wbm_dat_i = 32'h4433_2211;
    wbm_we_i  = 1'b1;
    wbm_sel_i = 4'hF;
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (wbs_stb_o) seen = 1'b1;
    end
    chk("drop_stb_seen", {63'd0, seen}, 64'd1);
    wbm_cyc_i = 1'b0;
    repeat (8) @(negedge clk);
    wbm_stb_i = 1'b0;
    chk("drop_count", 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) chk("drop_b0", 64'(log_q[0]), 64'({32'h400, 8'h11, 1'b1}));
    chk("drop_no_ack", 64'({ack_cycles, err_cycles}), 64'd0);
    clear_logs();
    access(32'h500, 32'h0, 1'b0, 4'h2, rdata, t_req);
    @(negedge clk);
    chk("after_drop_data", 64'(rdata), 64'h0000_EE00);
    chk("after_drop_count", 64'(log_q.size()), 64'd1);

    // Reset while waiting on a slave that does not respond
    clear_logs();
    slave_hold = 1'b1;
    wbm_adr_i = 32'h600;
    wbm_we_i  = 1'b0;
    wbm_sel_i = 4'hF;
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_stb_high", {63'd0, wbs_stb_o}, 64'd1);
    rst = 1'b1;
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", {51'd0, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbm_ack_o, wbm_err_o, wbs_dat_o},
        64'd0);
    chk("midrst_data", {wbs_adr_o, wbm_dat_o}, 64'd0);
    rst = 1'b0;
    slave_hold = 1'b0;
    @(negedge clk);
    clear_logs();
    access(32'h700, 32'h0, 1'b0, 4'h8, rdata, t_req);
    @(negedge clk);
    chk("post_rst_data", 64'(rdata), 64'h5A00_0000);
    chk("post_rst_count", 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) chk("post_rst_adr", 64'(log_q[0][40:9]), 64'h703);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
